mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DataWidth, default 32, bus/register data width; legal values 32 and 64.
REQ-002 Parameter AddrWidth, default 32, byte address width.
REQ-003 Parameter WordSize, default DataWidth/8, byte lanes per bus beat.
REQ-004 Parameter AllowMisaligned, default 1; 1 = split lane-crossing accesses into two beats, 0 = fault them.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  pipeline request valid.
REQ-008 req_ready  output  1  unit can accept a request.
REQ-009 alu_result  input  AddrWidth  byte address of access.
REQ-010 reg2_data  input  DataWidth  store data, right-aligned.
REQ-011 memory_read_enable  input  1  load request.
REQ-012 memory_write_enable  input  1  store request.
REQ-013 funct3  input  3  [1:0] size (0 byte, 1 half, 2 word, 3 double); [2] zero-extend on load.
REQ-014 resp_valid  output  1  one-cycle pulse: access complete.
REQ-015 wb_memory_read_data  output  DataWidth  extended load result, valid with resp_valid.
REQ-016 misaligned_fault  output  1  valid with resp_valid: access faulted, no bus traffic.
REQ-017 bus_req  output  1  RAM beat request.
REQ-018 bus_we  output  1  beat is a write.
REQ-019 address  output  AddrWidth  word-aligned beat address (low log2(WordSize) bits zero).
REQ-020 write_data  output  DataWidth  lane-positioned store data.
REQ-021 write_strobe  output  WordSize  byte-lane enables; zero on reads.
REQ-022 bus_ack  input  1  RAM beat complete; read_data valid in same cycle.
REQ-023 read_data  input  DataWidth  RAM read word.

Function
REQ-024 FSM states IDLE, BEAT1, BEAT2, RESP; req_ready = 1 only in IDLE.
REQ-025 Handshake: request captured (address, data, funct3, enables) when req_valid & req_ready; inputs ignored otherwise.
REQ-026 Read enable wins when both enables set; neither set -> IDLE->RESP, data 0, no fault, no bus beat.
REQ-027 Size bytes = 1<<funct3[1:0]; size 3 with DataWidth 32, or funct3 = 3'b011 as load when DataWidth 32, -> fault; stores ignore funct3[2].
REQ-028 offset = address mod WordSize; crossing = offset + size > WordSize.
REQ-029 Fault (illegal size, or crossing with AllowMisaligned=0): IDLE->RESP, misaligned_fault=1, data 0, bus_req never asserted.
REQ-030 Non-crossing access: IDLE->BEAT1->RESP; crossing with AllowMisaligned=1: IDLE->BEAT1->BEAT2->RESP.
REQ-031 BEAT1 address = aligned(addr); BEAT2 address = aligned(addr)+WordSize, wrapping modulo 2^AddrWidth.
REQ-032 bus_req, bus_we, address, write_data, write_strobe are registered, held stable from beat start until the cycle bus_ack=1, then change; ack in the first request cycle is legal.
REQ-033 Store: 2*DataWidth value = store data << (8*offset); strobe mask = ((1<<size)-1) << offset over 2*WordSize lanes; low halves drive BEAT1, high halves BEAT2.
REQ-034 Load: beat read_data captured at ack; result = ({beat2, beat1} >> 8*offset) truncated to size, sign-extended unless funct3[2]=1.
REQ-035 RESP lasts exactly one cycle: resp_valid=1, then IDLE; new request accepted no earlier than the following cycle.
REQ-036 Latency: request accepted cycle N, bus_req high N+1; with ack in the same cycle, resp_valid at N+2 (one beat) or N+3 (two beats); each ack wait cycle adds one.
REQ-037 bus_ack outside BEAT1/BEAT2 is ignored.

Reset
REQ-038 rst=0 at any time, including mid-beat: state IDLE, every output 0 except req_ready=1, captured registers cleared, pending beat abandoned.
REQ-039 First request accepted on the first rising edge with rst=1.

Verification
REQ-040 DataWidth 32, SB addr 0x1003 data 0xAB, ack immediate -> one beat, address 0x1000, strobe 4'b1000, write_data 0xAB000000, resp at N+2.
REQ-041 LH addr 0x2003, AllowMisaligned=1, words 0x2000=0x11223344, 0x2004=0x55667788 -> two beats, result 0xFFFF8811.
REQ-042 Same access, funct3=3'b101 -> 0x00008811; AllowMisaligned=0 -> fault=1, no bus_req, resp at N+1.
REQ-043 SW addr 0x3002 data 0xDEADBEEF, ack delayed 3 cycles per beat -> beat1 strobe 4'b1100 data 0xBEEF0000, beat2 0x3004 strobe 4'b0011 data 0x0000DEAD, outputs stable during waits.
REQ-044 DataWidth 64, LD addr 0x8 -> one beat, strobe 0, full 64-bit word returned; LD with DataWidth 32 -> fault.
REQ-045 rst low during BEAT2 wait -> bus_req 0 immediately, no resp_valid, next request after release completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit that turns one request into one or two aligned bus beats,
// splitting lane-crossing accesses or faulting them when misalignment is disallowed.
module mem_access_unit #(
    parameter int DataWidth       = 32,
    parameter int AddrWidth       = 32,
    parameter int WordSize        = DataWidth / 8,
    parameter bit AllowMisaligned = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [AddrWidth-1:0] alu_result,
    input  logic [DataWidth-1:0] reg2_data,
    input  logic                 memory_read_enable,
    input  logic                 memory_write_enable,
    input  logic [2:0]           funct3,
    output logic                 resp_valid,
    output logic [DataWidth-1:0] wb_memory_read_data,
    output logic                 misaligned_fault,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [AddrWidth-1:0] address,
    output logic [DataWidth-1:0] write_data,
    output logic [WordSize-1:0]  write_strobe,
    input  logic                 bus_ack,
    input  logic [DataWidth-1:0] read_data
);
    localparam int OffW = $clog2(WordSize);
    localparam logic [2*WordSize-1:0] LaneOne = 1;

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

    state_t                 state;
    logic                   is_load;
    logic                   zext;
    logic                   two_beat;
    logic [1:0]             size_r;
    logic [OffW-1:0]        off_r;
    logic [DataWidth-1:0]   data_hi;
    logic [DataWidth-1:0]   beat_lo;
    logic [WordSize-1:0]    strobe_hi;

    logic [OffW-1:0]        offset;
    logic                   rd_req;
    logic                   wr_req;
    logic                   crossing;
    logic                   fault;
    logic [4:0]             span;
    logic [2*DataWidth-1:0] st_wide;
    logic [2*WordSize-1:0]  st_mask;
    logic [DataWidth-1:0]   ld_result;
    logic                   last_beat;

    // Left-justify the selected field, then shift back down logically or arithmetically.
    function automatic logic [DataWidth-1:0] extend(input logic [2*DataWidth-1:0] pair,
                                                    input logic [OffW-1:0] off,
                                                    input logic [1:0] sz,
                                                    input logic zx);
        logic [DataWidth-1:0]        raw;
        logic [DataWidth-1:0]        v;
        logic signed [DataWidth-1:0] s;
        logic [7:0]                  sh;
        raw = DataWidth'(pair >> {off, 3'b000});
        sh  = 8'(DataWidth) - (8'd8 << sz);
        v   = raw << sh;
        s   = $signed(v) >>> sh;
        return zx ? (v >> sh) : $unsigned(s);
    endfunction

    always_comb begin
        offset    = alu_result[OffW-1:0];
        rd_req    = memory_read_enable;
        wr_req    = memory_write_enable & ~memory_read_enable;
        span      = 5'(offset) + (5'd1 << funct3[1:0]);
        crossing  = span > 5'(WordSize);
        fault     = (rd_req | wr_req) &
                    ((funct3[1:0] == 2'b11 && DataWidth == 32) | (crossing & !AllowMisaligned));
        st_wide   = {{DataWidth{1'b0}}, reg2_data} << {offset, 3'b000};
        st_mask   = ((LaneOne << (4'd1 << funct3[1:0])) - LaneOne) << offset;
        last_beat = state == BEAT2 || !two_beat;
        ld_result = extend(state == BEAT2 ? {read_data, beat_lo} : {{DataWidth{1'b0}}, read_data},
                           off_r, size_r, zext);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            req_ready           <= 1'b1;
            resp_valid          <= 1'b0;
            wb_memory_read_data <= '0;
            misaligned_fault    <= 1'b0;
            bus_req             <= 1'b0;
            bus_we              <= 1'b0;
            address             <= '0;
            write_data          <= '0;
            write_strobe        <= '0;
            is_load             <= 1'b0;
            zext                <= 1'b0;
            two_beat            <= 1'b0;
            size_r              <= '0;
            off_r               <= '0;
            data_hi             <= '0;
            beat_lo             <= '0;
            strobe_hi           <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    is_load   <= rd_req;
                    zext      <= funct3[2];
                    size_r    <= funct3[1:0];
                    off_r     <= offset;
                    two_beat  <= crossing;
                    data_hi   <= wr_req ? st_wide[2*DataWidth-1:DataWidth] : '0;
                    strobe_hi <= wr_req ? st_mask[2*WordSize-1:WordSize] : '0;
                    if (!(rd_req | wr_req) || fault) begin
                        state            <= RESP;
                        resp_valid       <= 1'b1;
                        misaligned_fault <= fault;
                    end else begin
                        state        <= BEAT1;
                        bus_req      <= 1'b1;
                        bus_we       <= wr_req;
                        address      <= {alu_result[AddrWidth-1:OffW], {OffW{1'b0}}};
                        write_data   <= wr_req ? st_wide[DataWidth-1:0] : '0;
                        write_strobe <= wr_req ? st_mask[WordSize-1:0] : '0;
                    end
                end
                BEAT1, BEAT2: if (bus_ack) begin
                    beat_lo <= read_data;
                    if (!last_beat) begin
                        state        <= BEAT2;
                        address      <= address + AddrWidth'(WordSize);
                        write_data   <= data_hi;
                        write_strobe <= strobe_hi;
                    end else begin
                        state               <= RESP;
                        bus_req             <= 1'b0;
                        bus_we              <= 1'b0;
                        address             <= '0;
                        write_data          <= '0;
                        write_strobe        <= '0;
                        resp_valid          <= 1'b1;
                        wb_memory_read_data <= is_load ? ld_result : '0;
                    end
                end
                default: begin
                    state               <= IDLE;
                    req_ready           <= 1'b1;
                    resp_valid          <= 1'b0;
                    misaligned_fault    <= 1'b0;
                    wb_memory_read_data <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench over three configurations (32-bit split, 32-bit fault, 64-bit)
// sharing one byte-addressed memory model.
module tb_mem_access_unit;
    typedef struct {
        logic [63:0] data;
        logic        fault;
        int          lat;
        int          t0;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  strb;
        logic [63:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_v = 1'b0;
    logic        mre = 1'b0;
    logic        mwe = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] alu = 32'b0;
    logic [63:0] r2 = 64'b0;
    int          sel = 0;
    int          ack_delay = 0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  mem [0:65535];
    resp_t       exp_q [3][$];
    beat_t       beat_q [3][$];
    wire  [2:0]  rdy;
    wire  [2:0]  breq;
    wire  [2:0]  rv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int DW = (k == 2) ? 64 : 32;
        localparam int WS = DW / 8;
        logic          req_ready, resp_valid, fault, bus_req, bus_we, ack;
        logic [DW-1:0] wb_data, write_data, rd_data;
        logic [31:0]   address;
        logic [WS-1:0] write_strobe;
        resp_t         e;

        mem_access_unit #(.DataWidth(DW), .AllowMisaligned(k == 1 ? 1'b0 : 1'b1)) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_v && sel == k), .req_ready(req_ready),
            .alu_result(alu), .reg2_data(r2[DW-1:0]),
            .memory_read_enable(mre), .memory_write_enable(mwe), .funct3(funct3),
            .resp_valid(resp_valid), .wb_memory_read_data(wb_data), .misaligned_fault(fault),
            .bus_req(bus_req), .bus_we(bus_we), .address(address),
            .write_data(write_data), .write_strobe(write_strobe),
            .bus_ack(ack), .read_data(rd_data)
        );

        assign rdy[k]  = req_ready;
        assign breq[k] = bus_req;
        assign rv[k]   = resp_valid;

        // Memory responder: acks after ack_delay wait cycles, checks beats against expectations.
        initial begin
            int          waits;
            logic [31:0] sa;
            logic [DW-1:0] sd;
            logic [WS-1:0] ss;
            logic        swe;
            beat_t       b;
            ack = 1'b0;
            rd_data = '0;
            waits = 0;
            forever begin
                @(negedge clk);
                ack = 1'b0;
                if (!bus_req) waits = 0;
                else begin
                    if (waits == 0) begin
                        sa = address; sd = write_data; ss = write_strobe; swe = bus_we;
                    end else
                        check($sformatf("u%0d_stable", k),
                              64'({address != sa, write_data != sd, write_strobe != ss, bus_we != swe}), 64'd0);
                    if (waits < ack_delay) waits++;
                    else begin
                        waits = 0;
                        ack = 1'b1;
                        for (int i = 0; i < WS; i++) rd_data[8*i+:8] = mem[16'(address + 32'(i))];
                        if (bus_we)
                            for (int i = 0; i < WS; i++)
                                if (write_strobe[i]) mem[16'(address + 32'(i))] = write_data[8*i+:8];
                        if (beat_q[k].size() == 0) check($sformatf("u%0d_beat_unexpected", k), 64'd1, 64'd0);
                        else begin
                            b = beat_q[k].pop_front();
                            check($sformatf("u%0d_beat_addr", k), 64'(address), 64'(b.addr));
                            check($sformatf("u%0d_beat_we", k), 64'(bus_we), 64'(b.we));
                            check($sformatf("u%0d_beat_strobe", k), 64'(write_strobe), 64'(b.strb));
                            if (b.we) check($sformatf("u%0d_beat_data", k), 64'(write_data), b.data);
                        end
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (resp_valid) begin
                if (exp_q[k].size() == 0) check($sformatf("u%0d_resp_unexpected", k), 64'd1, 64'd0);
                else begin
                    e = exp_q[k].pop_front();
                    check($sformatf("u%0d_resp_data", k), 64'(wb_data), e.data);
                    check($sformatf("u%0d_resp_fault", k), 64'(fault), 64'(e.fault));
                    check($sformatf("u%0d_resp_latency", k), 64'(cyc - e.t0), 64'(e.lat));
                end
            end
        end
    end

    task automatic put32(input logic [15:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) mem[a + 16'(i)] = v[8*i+:8];
    endtask

    task automatic beat(input int k, input logic [31:0] a, input logic we, input logic [7:0] s,
                        input logic [63:0] d);
        beat_q[k].push_back('{a, we, s, d});
    endtask

    task automatic issue(input int k, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [63:0] d,
                         input logic [63:0] ed, input logic ef, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        sel = k; mre = rd; mwe = wr; funct3 = f3; alu = a; r2 = d; req_v = 1'b1;
        while (!rdy[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("ready_timeout", 64'd0, 64'd1);
            req_v = 1'b0;
        end else begin
            @(posedge clk);
            exp_q[k].push_back('{ed, ef, lat, cyc});
            #1;
            req_v = 1'b0; alu = ~a; r2 = ~d; funct3 = ~f3;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("drain_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("[TB] watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        put32(16'h2000, 32'h11223344);
        put32(16'h2004, 32'h55667788);
        put32(16'hFFFC, 32'h12340000);
        put32(16'h0000, 32'h00005678);
        put32(16'h0008, 32'h89ABCDEF);
        put32(16'h000C, 32'h01234567);
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(rdy), 64'h7);
        check("rst_bus_req", 64'(breq), 64'h0);
        check("rst_resp_valid", 64'(rv), 64'h0);
        rst = 1'b1;

        // 32-bit, misaligned accesses split
        beat(0, 32'h1000, 1, 8'b1000, 64'hAB000000);
        issue(0, 0, 1, 3'b000, 32'h1003, 64'hAB, 64'h0, 0, 2);
        beat(0, 32'h2000, 0, 8'h0, 64'h0);
        beat(0, 32'h2004, 0, 8'h0, 64'h0);
        issue(0, 1, 0, 3'b001, 32'h2003, 64'h0, 64'hFFFF8811, 0, 3);
        beat(0, 32'h2000, 0, 8'h0, 64'h0);
        beat(0, 32'h2004, 0, 8'h0, 64'h0);
        issue(0, 1, 0, 3'b101, 32'h2003, 64'h0, 64'h00008811, 0, 3);
        drain();
        ack_delay = 3;
        beat(0, 32'h3000, 1, 8'b1100, 64'hBEEF0000);
        beat(0, 32'h3004, 1, 8'b0011, 64'h0000DEAD);
        issue(0, 0, 1, 3'b010, 32'h3002, 64'hDEADBEEF, 64'h0, 0, 9);
        drain();
        ack_delay = 0;
        beat(0, 32'h3000, 0, 8'h0, 64'h0);
        issue(0, 1, 0, 3'b010, 32'h3000, 64'h0, 64'hBEEF0000, 0, 2);
        beat(0, 32'h3000, 0, 8'h0, 64'h0);
        issue(0, 1, 0, 3'b000, 32'h3003, 64'h0, 64'hFFFFFFBE, 0, 2);
        beat(0, 32'h3000, 0, 8'h0, 64'h0);
        issue(0, 1, 0, 3'b100, 32'h3003, 64'h0, 64'h000000BE, 0, 2);
        beat(0, 32'h2004, 0, 8'h0, 64'h0);
        beat(0, 32'h2008, 0, 8'h0, 64'h0);
        issue(0, 1, 0, 3'b010, 32'h2006, 64'h0, 64'h00005566, 0, 3);
        issue(0, 0, 0, 3'b010, 32'h2000, 64'h0, 64'h0, 0, 1);
        issue(0, 1, 0, 3'b011, 32'h2000, 64'h0, 64'h0, 1, 1);
        issue(0, 0, 1, 3'b011, 32'h2000, 64'h5, 64'h0, 1, 1);
        beat(0, 32'h2000, 0, 8'h0, 64'h0);
        issue(0, 1, 1, 3'b010, 32'h2000, 64'hFFFFFFFF, 64'h11223344, 0, 2);
        beat(0, 32'hFFFFFFFC, 0, 8'h0, 64'h0);
        beat(0, 32'h00000000, 0, 8'h0, 64'h0);
        issue(0, 1, 0, 3'b010, 32'hFFFFFFFE, 64'h0, 64'h56781234, 0, 3);

        // 32-bit, misaligned accesses fault
        issue(1, 1, 0, 3'b001, 32'h2003, 64'h0, 64'h0, 1, 1);
        beat(1, 32'h2000, 0, 8'h0, 64'h0);
        issue(1, 1, 0, 3'b001, 32'h2002, 64'h0, 64'h00001122, 0, 2);

        // 64-bit
        beat(2, 32'h8, 0, 8'h0, 64'h0);
        issue(2, 1, 0, 3'b011, 32'h8, 64'h0, 64'h0123456789ABCDEF, 0, 2);
        beat(2, 32'h10, 1, 8'hFF, 64'hCAFEBABE12345678);
        issue(2, 0, 1, 3'b011, 32'h10, 64'hCAFEBABE12345678, 64'h0, 0, 2);
        beat(2, 32'h10, 0, 8'h0, 64'h0);
        issue(2, 1, 0, 3'b010, 32'h14, 64'h0, 64'hFFFFFFFFCAFEBABE, 0, 2);
        beat(2, 32'h10, 0, 8'h0, 64'h0);
        issue(2, 1, 0, 3'b110, 32'h14, 64'h0, 64'h00000000CAFEBABE, 0, 2);
        drain();

        // reset while the second beat is waiting for its ack
        ack_delay = 3;
        beat(0, 32'h3000, 1, 8'b1100, 64'hBEEF0000);
        beat(0, 32'h3004, 1, 8'b0011, 64'h0000DEAD);
        issue(0, 0, 1, 3'b010, 32'h3002, 64'hDEADBEEF, 64'h0, 0, 9);
        n = 0;
        while (beat_q[0].size() != 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("beat1_seen", 64'(n < 100), 64'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midbeat_rst_bus_req", 64'(breq[0]), 64'd0);
        check("midbeat_rst_ready", 64'(rdy[0]), 64'd1);
        check("midbeat_rst_resp", 64'(rv[0]), 64'd0);
        exp_q[0].delete();
        beat_q[0].delete();
        @(negedge clk);
        rst = 1'b1;
        ack_delay = 0;
        beat(0, 32'h2000, 0, 8'h0, 64'h0);
        issue(0, 1, 0, 3'b010, 32'h2000, 64'h0, 64'h11223344, 0, 2);
        drain();
        check("beats_left", 64'(beat_q[0].size() + beat_q[1].size() + beat_q[2].size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
